// File: rtl/uart_rx_frame_if.sv
// Valid/ready frame handshake between uart_rx_frame (master) and its consumer (slave).
// DATA_BITS must match the receiver's DATA_BITS parameter.
interface uart_rx_frame_if #(
   parameter int DATA_BITS = 8
);
   logic                 o_Rx_Valid;
   logic                 i_Rx_Ready;
   logic [DATA_BITS-1:0] o_Rx_Data;
   logic                 o_Parity_Err;
   logic                 o_Frame_Err;
   logic                 o_Overrun;

   modport master (
      output o_Rx_Valid, o_Rx_Data, o_Parity_Err, o_Frame_Err, o_Overrun,
      input  i_Rx_Ready
   );

   modport slave (
      input  o_Rx_Valid, o_Rx_Data, o_Parity_Err, o_Frame_Err, o_Overrun,
      output i_Rx_Ready
   );
endinterface

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: 5..9 data bits, none/odd/even parity, 1 or 2 stop bits,
// 3-sample majority per bit, one-entry valid/ready output buffer with sticky overrun.
module uart_rx_frame #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int CNT_W        = 18
) (
   input  logic           i_Clock,
   input  logic           reset,
   input  logic           receive,
   input  logic           i_Rx_Serial,
   output logic           o_Busy,
   uart_rx_frame_if.master bus
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;

   localparam int              MID        = CLKS_PER_BIT / 2;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'(MID);
   localparam logic [CNT_W-1:0] CNT_MID_M1 = CNT_W'(MID - 1);
   localparam logic [CNT_W-1:0] CNT_MID_M2 = CNT_W'(MID - 2);
   localparam logic [3:0]       DATA_LAST  = 4'(DATA_BITS - 1);
   localparam logic [3:0]       STOP_LAST  = 4'(STOP_BITS - 1);
   localparam logic             PAR_ODD    = (PARITY == 1);

   logic                 rx_meta, rx;
   logic [2:0]           state;
   logic [CNT_W-1:0]     cnt;
   logic [3:0]           bit_idx;
   logic                 samp_a, samp_b;
   logic [DATA_BITS-1:0] shift;
   logic                 par_err, frame_err;
   logic                 armed;
   logic                 maj, at_sample, at_last;

   assign maj       = (samp_a & samp_b) | (samp_a & rx) | (samp_b & rx);
   assign at_sample = (cnt == CNT_MID);
   assign at_last   = (cnt == CNT_LAST);
   assign o_Busy    = (state != ST_IDLE);

   // Both stages reset high so a reset never looks like a start edge.
   always_ff @(posedge i_Clock) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx      <= 1'b1;
      end else begin
         rx_meta <= i_Rx_Serial;
         rx      <= rx_meta;
      end
   end

   // NOTE: sequential state uses <= only, so every register sees pre-edge values of the others.
   always_ff @(posedge i_Clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         samp_a    <= 1'b0;
         samp_b    <= 1'b0;
         shift     <= '0;
         par_err   <= 1'b0;
         frame_err <= 1'b0;
         armed     <= 1'b0;
      end else begin
         if (cnt == CNT_MID_M2) samp_a <= rx;
         if (cnt == CNT_MID_M1) samp_b <= rx;
         if (state != ST_IDLE) cnt <= at_last ? '0 : cnt + CNT_W'(1);

         case (state)
            ST_IDLE: begin
               cnt     <= '0;
               bit_idx <= '0;
               // A start is only accepted after the line has been seen high, so a held break cannot retrigger.
               if (rx) begin
                  armed <= 1'b1;
               end else if (armed && receive) begin
                  state     <= ST_START;
                  armed     <= 1'b0;
                  par_err   <= 1'b0;
                  frame_err <= 1'b0;
               end
            end
            ST_START: begin
               if (at_sample && maj) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else if (at_last) begin
                  state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (at_sample) shift <= {maj, shift[DATA_BITS-1:1]};
               if (at_last) begin
                  if (bit_idx == DATA_LAST) begin
                     bit_idx <= '0;
                     state   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_idx <= bit_idx + 4'd1;
                  end
               end
            end
            ST_PARITY: begin
               if (at_sample) par_err <= (^shift ^ maj) ^ PAR_ODD;
               if (at_last) state <= ST_STOP;
            end
            ST_STOP: begin
               // The last stop bit ends at its sample point so a following start edge is not missed.
               if (at_sample) begin
                  if (!maj) frame_err <= 1'b1;
                  if (bit_idx == STOP_LAST) begin
                     state <= ST_DONE;
                     cnt   <= '0;
                  end
               end else if (at_last) begin
                  bit_idx <= bit_idx + 4'd1;
               end
            end
            ST_DONE: begin
               state   <= ST_IDLE;
               cnt     <= '0;
               bit_idx <= '0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   logic accept, load_try;
   assign accept   = bus.o_Rx_Valid & bus.i_Rx_Ready;
   assign load_try = (state == ST_DONE);

   always_ff @(posedge i_Clock) begin
      if (reset) begin
         bus.o_Rx_Valid   <= 1'b0;
         bus.o_Rx_Data    <= '0;
         bus.o_Parity_Err <= 1'b0;
         bus.o_Frame_Err  <= 1'b0;
         bus.o_Overrun    <= 1'b0;
      end else if (load_try && (!bus.o_Rx_Valid || accept)) begin
         bus.o_Rx_Valid   <= 1'b1;
         bus.o_Rx_Data    <= shift;
         bus.o_Parity_Err <= par_err;
         bus.o_Frame_Err  <= frame_err;
         if (accept) bus.o_Overrun <= 1'b0;
      end else if (load_try) begin
         bus.o_Overrun <= 1'b1;
      end else if (accept) begin
         bus.o_Rx_Valid <= 1'b0;
         bus.o_Overrun  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: an 8N1 instance and a 7E2 instance at 16 clocks per bit.
module tb_uart_rx_frame;

   localparam int CPB = 16;

   logic clk = 1'b0;
   logic rst, receive, rx_a, rx_b, busy_a, busy_b;
   int   checks = 0;
   int   errors = 0;

   uart_rx_frame_if #(.DATA_BITS(8)) bus_a ();
   uart_rx_frame_if #(.DATA_BITS(7)) bus_b ();

   uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CNT_W(18)) dut_a (
      .i_Clock(clk), .reset(rst), .receive(receive), .i_Rx_Serial(rx_a), .o_Busy(busy_a), .bus(bus_a)
   );

   uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .CNT_W(18)) dut_b (
      .i_Clock(clk), .reset(rst), .receive(receive), .i_Rx_Serial(rx_b), .o_Busy(busy_b), .bus(bus_b)
   );

   always #5 clk = ~clk;

   // Capture every accepted frame and count busy cycles, sampled on the falling edge.
   int         acc_a = 0, acc_b = 0, busy_cyc_a = 0;
   logic [7:0] cap_data_a = '0;
   logic [6:0] cap_data_b = '0;
   logic       cap_pe_a = 0, cap_fe_a = 0, cap_pe_b = 0, cap_fe_b = 0;

   always @(negedge clk) begin
      if (bus_a.o_Rx_Valid && bus_a.i_Rx_Ready) begin
         acc_a++; cap_data_a = bus_a.o_Rx_Data; cap_pe_a = bus_a.o_Parity_Err; cap_fe_a = bus_a.o_Frame_Err;
      end
      if (bus_b.o_Rx_Valid && bus_b.i_Rx_Ready) begin
         acc_b++; cap_data_b = bus_b.o_Rx_Data; cap_pe_b = bus_b.o_Parity_Err; cap_fe_b = bus_b.o_Frame_Err;
      end
      if (busy_a) busy_cyc_a++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic set_line(input int dut, input logic v);
      if (dut == 0) rx_a = v;
      else          rx_b = v;
   endtask

   // One bit period; optionally invert the line for a single cycle at glitch_off.
   task automatic drive_bit(input int dut, input logic v, input int glitch_off);
      for (int c = 0; c < CPB; c++) begin
         set_line(dut, (c == glitch_off) ? ~v : v);
         tick();
      end
   endtask

   task automatic send_frame(input int dut, input logic [8:0] data, input int nbits, input bit has_par,
                             input logic par_bit, input int nstop, input logic stop_val,
                             input int glitch_bit, input int glitch_off);
      drive_bit(dut, 1'b0, -1);
      for (int i = 0; i < nbits; i++) drive_bit(dut, data[i], (i == glitch_bit) ? glitch_off : -1);
      if (has_par) drive_bit(dut, par_bit, -1);
      for (int s = 0; s < nstop; s++) drive_bit(dut, stop_val, -1);
   endtask

   task automatic send_a(input logic [7:0] data);
      send_frame(0, {1'b0, data}, 8, 1'b0, 1'b0, 1, 1'b1, -1, -1);
      idle(2 * CPB);
   endtask

   task automatic test_reset();
      if (bus_a.o_Rx_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus_a.o_Rx_Valid); end
      if (bus_a.o_Rx_Data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus_a.o_Rx_Data); end
      if (bus_a.o_Parity_Err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", bus_a.o_Parity_Err); end
      if (bus_a.o_Frame_Err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", bus_a.o_Frame_Err); end
      if (bus_a.o_Overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", bus_a.o_Overrun); end
      if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
      if (bus_b.o_Rx_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid_b: got %b want 0", bus_b.o_Rx_Valid); end
      checks += 7;
   endtask

   task automatic test_basic_8n1();
      int base = acc_a;
      int bc = busy_cyc_a;
      send_a(8'hA5);
      checks += 6;
      if (acc_a !== base + 1) begin errors++; $display("FAIL basic_count: got %0d want %0d", acc_a, base + 1); end
      if (cap_data_a !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", cap_data_a); end
      if (cap_pe_a !== 1'b0) begin errors++; $display("FAIL basic_perr: got %b want 0", cap_pe_a); end
      if (cap_fe_a !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b want 0", cap_fe_a); end
      if (bus_a.o_Rx_Valid !== 1'b0) begin errors++; $display("FAIL basic_valid_after: got %b want 0", bus_a.o_Rx_Valid); end
      if (busy_cyc_a == bc) begin errors++; $display("FAIL basic_busy: got 0 busy cycles want >0"); end
   endtask

   task automatic test_parity_7e2();
      int base = acc_b;
      // 0x41 has two ones: even parity bit is 0, so a 1 is an error.
      send_frame(1, 9'h041, 7, 1'b1, 1'b1, 2, 1'b1, -1, -1);
      idle(2 * CPB);
      checks += 4;
      if (acc_b !== base + 1) begin errors++; $display("FAIL par_bad_count: got %0d want %0d", acc_b, base + 1); end
      if (cap_data_b !== 7'h41) begin errors++; $display("FAIL par_bad_data: got %h want 41", cap_data_b); end
      if (cap_pe_b !== 1'b1) begin errors++; $display("FAIL par_bad_perr: got %b want 1", cap_pe_b); end
      if (cap_fe_b !== 1'b0) begin errors++; $display("FAIL par_bad_ferr: got %b want 0", cap_fe_b); end
      send_frame(1, 9'h041, 7, 1'b1, 1'b0, 2, 1'b1, -1, -1);
      idle(2 * CPB);
      checks += 3;
      if (acc_b !== base + 2) begin errors++; $display("FAIL par_ok_count: got %0d want %0d", acc_b, base + 2); end
      if (cap_data_b !== 7'h41) begin errors++; $display("FAIL par_ok_data: got %h want 41", cap_data_b); end
      if (cap_pe_b !== 1'b0) begin errors++; $display("FAIL par_ok_perr: got %b want 0", cap_pe_b); end
   endtask

   task automatic test_frame_err();
      int base = acc_a;
      send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b0, -1, -1);
      idle(3 * CPB);
      checks += 5;
      if (acc_a !== base + 1) begin errors++; $display("FAIL ferr_count: got %0d want %0d", acc_a, base + 1); end
      if (cap_data_a !== 8'h3C) begin errors++; $display("FAIL ferr_data: got %h want 3c", cap_data_a); end
      if (cap_fe_a !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b want 1", cap_fe_a); end
      if (cap_pe_a !== 1'b0) begin errors++; $display("FAIL ferr_perr: got %b want 0", cap_pe_a); end
      if (busy_a !== 1'b0) begin errors++; $display("FAIL ferr_held_busy: got %b want 0", busy_a); end
      set_line(0, 1'b1);
      idle(2 * CPB);
      checks += 1;
      if (acc_a !== base + 1) begin errors++; $display("FAIL ferr_no_retrigger: got %0d want %0d", acc_a, base + 1); end
      send_a(8'h96);
      checks += 3;
      if (acc_a !== base + 2) begin errors++; $display("FAIL ferr_recover_count: got %0d want %0d", acc_a, base + 2); end
      if (cap_data_a !== 8'h96) begin errors++; $display("FAIL ferr_recover_data: got %h want 96", cap_data_a); end
      if (cap_fe_a !== 1'b0) begin errors++; $display("FAIL ferr_recover_flag: got %b want 0", cap_fe_a); end
   endtask

   task automatic test_overrun();
      int base;
      bus_a.i_Rx_Ready = 1'b0;
      base = acc_a;
      send_a(8'h11);
      checks += 3;
      if (bus_a.o_Rx_Valid !== 1'b1) begin errors++; $display("FAIL ovr_first_valid: got %b want 1", bus_a.o_Rx_Valid); end
      if (bus_a.o_Rx_Data !== 8'h11) begin errors++; $display("FAIL ovr_first_data: got %h want 11", bus_a.o_Rx_Data); end
      if (bus_a.o_Overrun !== 1'b0) begin errors++; $display("FAIL ovr_first_flag: got %b want 0", bus_a.o_Overrun); end
      send_a(8'h22);
      checks += 3;
      if (bus_a.o_Rx_Valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b want 1", bus_a.o_Rx_Valid); end
      if (bus_a.o_Rx_Data !== 8'h11) begin errors++; $display("FAIL ovr_data_kept: got %h want 11", bus_a.o_Rx_Data); end
      if (bus_a.o_Overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", bus_a.o_Overrun); end
      bus_a.i_Rx_Ready = 1'b1;
      tick();
      checks += 4;
      if (bus_a.o_Rx_Valid !== 1'b0) begin errors++; $display("FAIL ovr_accept_valid: got %b want 0", bus_a.o_Rx_Valid); end
      if (bus_a.o_Overrun !== 1'b0) begin errors++; $display("FAIL ovr_accept_clear: got %b want 0", bus_a.o_Overrun); end
      if (cap_data_a !== 8'h11) begin errors++; $display("FAIL ovr_accept_data: got %h want 11", cap_data_a); end
      if (acc_a !== base + 1) begin errors++; $display("FAIL ovr_accept_count: got %0d want %0d", acc_a, base + 1); end
   endtask

   task automatic test_glitch();
      int base = acc_a;
      set_line(0, 1'b0);
      idle(3);
      set_line(0, 1'b1);
      idle(3 * CPB);
      checks += 3;
      if (acc_a !== base) begin errors++; $display("FAIL glitch_start_count: got %0d want %0d", acc_a, base); end
      if (bus_a.o_Rx_Valid !== 1'b0) begin errors++; $display("FAIL glitch_start_valid: got %b want 0", bus_a.o_Rx_Valid); end
      if (busy_a !== 1'b0) begin errors++; $display("FAIL glitch_start_busy: got %b want 0", busy_a); end
      // Single-cycle inversion right at the centre of bit 0, once high-going and once low-going.
      send_frame(0, 9'h042, 8, 1'b0, 1'b0, 1, 1'b1, 0, 8);
      idle(2 * CPB);
      checks += 2;
      if (acc_a !== base + 1) begin errors++; $display("FAIL glitch_hi_count: got %0d want %0d", acc_a, base + 1); end
      if (cap_data_a !== 8'h42) begin errors++; $display("FAIL glitch_hi_data: got %h want 42", cap_data_a); end
      send_frame(0, 9'h0BD, 8, 1'b0, 1'b0, 1, 1'b1, 0, 8);
      idle(2 * CPB);
      checks += 2;
      if (acc_a !== base + 2) begin errors++; $display("FAIL glitch_lo_count: got %0d want %0d", acc_a, base + 2); end
      if (cap_data_a !== 8'hBD) begin errors++; $display("FAIL glitch_lo_data: got %h want bd", cap_data_a); end
   endtask

   task automatic test_reset_abort();
      int base = acc_a;
      drive_bit(0, 1'b0, -1);
      for (int i = 0; i < 3; i++) drive_bit(0, 1'b0, -1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_line(0, 1'b1);
      checks += 2;
      if (busy_a !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy_a); end
      if (bus_a.o_Rx_Valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", bus_a.o_Rx_Valid); end
      idle(3 * CPB);
      checks += 1;
      if (acc_a !== base) begin errors++; $display("FAIL abort_count: got %0d want %0d", acc_a, base); end
      send_a(8'h5A);
      checks += 2;
      if (acc_a !== base + 1) begin errors++; $display("FAIL abort_next_count: got %0d want %0d", acc_a, base + 1); end
      if (cap_data_a !== 8'h5A) begin errors++; $display("FAIL abort_next_data: got %h want 5a", cap_data_a); end
   endtask

   task automatic test_receive_gate();
      int base = acc_a;
      int bc = busy_cyc_a;
      receive = 1'b0;
      send_a(8'h77);
      checks += 2;
      if (acc_a !== base) begin errors++; $display("FAIL gate_count: got %0d want %0d", acc_a, base); end
      if (busy_cyc_a !== bc) begin errors++; $display("FAIL gate_busy: got %0d busy cycles want 0", busy_cyc_a - bc); end
      receive = 1'b1;
      send_a(8'h77);
      checks += 2;
      if (acc_a !== base + 1) begin errors++; $display("FAIL gate_on_count: got %0d want %0d", acc_a, base + 1); end
      if (cap_data_a !== 8'h77) begin errors++; $display("FAIL gate_on_data: got %h want 77", cap_data_a); end
   endtask

   initial begin
      rst = 1'b1;
      receive = 1'b1;
      rx_a = 1'b1;
      rx_b = 1'b1;
      bus_a.i_Rx_Ready = 1'b1;
      bus_b.i_Rx_Ready = 1'b1;
      idle(3);
      rst = 1'b0;
      test_reset();
      idle(4);
      test_basic_8n1();
      test_parity_7e2();
      test_frame_err();
      test_overrun();
      test_glitch();
      test_reset_abort();
      test_receive_gate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Parametrised UART receiver, successor to the fixed 8N1 receiver in the host-link path.
- Supports 5–9 data bits, none/odd/even parity and 1 or 2 stop bits.
- Samples each bit with a 3-sample majority vote and reports parity and framing errors.
- Presents each byte through a one-entry valid/ready buffer with a sticky overrun flag, so the downstream command parser can stall without losing framing.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit (minimum 8).
- DATA_BITS, 8, data bits per frame (5..9).
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame (1 or 2).
- CNT_W, 18, bit-period counter width; must hold CLKS_PER_BIT-1.

Ports:
- i_Clock  in  1  clock.
- reset  in  1  synchronous, active-high.
- receive  in  1  enables start-bit detection.
- i_Rx_Serial  in  1  asynchronous serial line, idles high.
- o_Rx_Valid  out  1  buffered frame available.
- i_Rx_Ready  in  1  consumer accepts the frame when o_Rx_Valid=1.
- o_Rx_Data  out  DATA_BITS  received data, LSB first on the line.
- o_Parity_Err  out  1  parity mismatch on the buffered frame; always 0 when PARITY=0.
- o_Frame_Err  out  1  at least one stop bit sampled 0 on the buffered frame.
- o_Overrun  out  1  sticky; a frame was dropped because the buffer was full.
- o_Busy  out  1  high in every state except IDLE.

Behaviour:
- Interface: reset is synchronous, active-high; clock is i_Clock.
- Input: i_Rx_Serial passes through a 2-FF synchroniser; both stages reset to 1. All logic uses the synchronised value `rx`.
- Reset values: o_Rx_Valid=0, o_Rx_Data=0, o_Parity_Err=0, o_Frame_Err=0, o_Overrun=0, o_Busy=0. State goes to IDLE, counters to 0. Reset asserted mid-frame abandons the frame; nothing is delivered.
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- Bit counter: cnt runs 0..CLKS_PER_BIT-1 within each bit, then wraps to 0 and the next bit begins.
- Sample point: at cnt == CLKS_PER_BIT/2 (integer division), bit value = majority of rx at cnt = CLKS_PER_BIT/2-2, CLKS_PER_BIT/2-1 and CLKS_PER_BIT/2.
- IDLE: if receive=1 and rx=0, go to START with cnt=0. receive=0 blocks start detection only.
- START: at the sample point, majority 1 → false start, return to IDLE with no flags changed. Majority 0 → continue to DATA at the bit boundary.
- DATA: shift DATA_BITS samples in LSB-first, then go to PARITY if PARITY≠0, else STOP.
- PARITY: compute XOR of data bits and the parity sample. Error if XOR≠1 for odd, or XOR≠0 for even.
- STOP: sample each of the STOP_BITS bits; any 0 sets the frame-error flag. The final stop bit does not wait for its full period: at its sample point go to DONE.
- DONE (one cycle): attempt to load the buffer, then return to IDLE.
  - A new start edge is therefore detectable from the second half of the last stop bit onward.
  - A stop-bit 0 (break or framing error) still returns to IDLE. IDLE re-detects rx=0 only after rx has been seen high once, so a held-low line does not retrigger.
- Buffer loading:
  - Buffer empty, or o_Rx_Valid&i_Rx_Ready in the same cycle: load data and error flags; o_Rx_Valid=1 in the next cycle. Simultaneous accept and load produces no overrun.
  - Otherwise: discard the new frame, keep the old one, set o_Overrun.
- Handshake: o_Rx_Valid, o_Rx_Data and the error flags hold stable until accepted (valid&ready). The accept cycle clears o_Rx_Valid unless a load happens in the same cycle.
- o_Overrun: cleared only by reset or by an accept cycle with no simultaneous overrun.
- Latency: o_Rx_Valid rises 2 cycles after the final stop-bit sample point (DONE cycle, then register), plus the 2-cycle synchroniser delay from the pin.
- Busy: o_Busy=1 from START through DONE.

Test Plan:
- CLKS_PER_BIT=16, 8N1, send 0xA5 with i_Rx_Ready=1 → one o_Rx_Valid pulse, o_Rx_Data=0xA5, both error flags 0.
- 7E2, send 0x41 with parity bit 1 (incorrect) → o_Rx_Data=0x41, o_Parity_Err=1. Then send with parity bit 0 → o_Parity_Err=0.
- 8N1, send 0x3C with stop bit 0 → o_Frame_Err=1, data 0x3C. Line then held low 3 bit-times → no further o_Rx_Valid until after rx returns high.
- i_Rx_Ready=0, send 0x11 then 0x22 → o_Rx_Data stays 0x11 and o_Overrun=1. Assert ready → 0x11 accepted, o_Rx_Valid=0, o_Overrun=0.
- Glitch: 3-cycle low pulse on an idle line, and a 1-cycle high spike at a data-bit sample point → no false frame; data unaffected by the majority vote.
- Reset asserted mid-DATA for 1 cycle, then a clean 0x5A frame → no output from the aborted frame, 0x5A delivered; receive=0 during a start edge → no reception.
